// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter sharing one FP32 adder among NUM_REQ requesters.
// Subtraction is done by flipping the sign of b before issue.
// Ports: clock, reset (async, active-high); req/req_sub/req_a/req_b in;
// grant/resp_valid/resp_data/resp_err/busy out; fpu_start/fpu_a/fpu_b to
// the adder, fpu_done/fpu_result back.
// Optional watchdog with late-done flush: FP_ARB_TIMEOUT_EN.
module fp_addsub_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_sub,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  output logic                  busy,
  output logic                  fpu_start,
  output logic [31:0]           fpu_a,
  output logic [31:0]           fpu_b,
  input  logic                  fpu_done,
  input  logic [31:0]           fpu_result
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESPOND,
    S_FLUSH
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      sel;
  logic               found;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        sel_a, sel_b;
  int                 idx;

`ifdef FP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  logic tmo_unused;
  assign tmo_unused = (TIMEOUT_CYCLES > 0);
`endif

  // First set request searching upward from ptr+1, wrapping.
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_comb begin
    sel_a = req_a[32*int'(sel) +: 32];
    sel_b = req_b[32*int'(sel) +: 32];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
`ifdef FP_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          a_d          = sel_a;
          b_d          = req_sub[sel] ?
                         {~sel_b[31], sel_b[30:0]} : sel_b;
          ptr_d        = sel;
          state_d      = S_ISSUE;
`ifdef FP_ARB_TIMEOUT_EN
          err_d        = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef FP_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (fpu_done) begin
          data_d  = fpu_result;
          state_d = S_RESPOND;
        end
`ifdef FP_ARB_TIMEOUT_EN
        else if (cnt_q == T_LAST) begin
          data_d  = QNAN;
          err_d   = 1'b1;
          state_d = S_RESPOND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESPOND: begin
        grant_d = '0;
        state_d = S_IDLE;
`ifdef FP_ARB_TIMEOUT_EN
        cnt_d   = '0;
        // A timed-out op may still deliver a done; soak it up.
        if (err_q) state_d = S_FLUSH;
`endif
      end
`ifdef FP_ARB_TIMEOUT_EN
      S_FLUSH: begin
        if (fpu_done || cnt_q == T_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
    end
  end

`ifdef FP_ARB_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign resp_err = err_q & (state_q == S_RESPOND);
`else
  assign resp_err = 1'b0;
`endif

  assign grant      = grant_q;
  assign resp_valid = (state_q == S_RESPOND) ? grant_q : '0;
  assign resp_data  = data_q;
  assign busy       = (state_q != S_IDLE);
  assign fpu_start  = (state_q == S_ISSUE);
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Self-checking bench for fp_addsub_arbiter.
// Random requesters + adder model, scoreboard checked every cycle.
module tb_fp_addsub_arbiter;
  localparam int N   = 4;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_sub = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [N-1:0]    grant, resp_valid;
  logic [31:0]     resp_data, fpu_a, fpu_b, fpu_result;
  logic            resp_err, busy, fpu_start, fpu_done;

  logic        man_done = 1'b0;
  logic [31:0] man_res = '0;
  logic        auto_done = 1'b0;
  logic [31:0] auto_res = '0;
  assign fpu_done   = man_done | auto_done;
  assign fpu_result = man_done ? man_res : auto_res;

  fp_addsub_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clk), .reset(rst),
    .req(req), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b),
    .grant(grant), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .fpu_start(fpu_start),
    .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, got, exp, $time);
    end
  endtask

  // FP32 <-> real, exact for the small integers used here.
  function automatic real s2d(input logic [31:0] s);
    if (s[30:23] == 8'd0) return 0.0;
    return $bitstoreal({s[31], 11'(s[30:23]) + 11'd896,
                        s[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] d2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a,
                                       input logic [31:0] b);
    return d2s(s2d(a) + s2d(b));
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [31:0] v;
    v = d2s(real'($urandom_range(0, 200)));
    if ($urandom_range(0, 1) == 1) v[31] = ~v[31];
    return v;
  endfunction

  // Adder model: done L cycles after start.
  int          auto_en = 1;
  int          lat_fix = 5;
  int          acnt = 0;
  logic [31:0] pa, pb;

  always @(negedge clk) begin
    auto_done = 1'b0;
    if (rst) begin
      acnt = 0;
    end else begin
      if (acnt > 0) begin
        acnt--;
        if (acnt == 0) begin
          auto_done = 1'b1;
          auto_res  = fadd(pa, pb);
        end
      end
      if (fpu_start && auto_en != 0) begin
        acnt = (lat_fix > 0) ? lat_fix : $urandom_range(1, 6);
        pa   = fpu_a;
        pb   = fpu_b;
      end
    end
  end

  // Reference model: transaction phases from the arbiter's rules.
  int          ph = 0;
  int          m_ptr = N - 1;
  int          m_sel = 0;
  int          m_cnt = 0;
  logic [31:0] m_a, m_b, m_data;
  logic        m_err = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (p + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] oh;
    logic [31:0]  bb;
    oh = '0;
    oh[m_sel] = 1'b1;
    case (ph)
      0: begin
        chk("idle_outs", {busy, fpu_start, grant, resp_valid}, 0);
        if (|req) begin
          m_sel = pick(req, m_ptr);
          m_ptr = m_sel;
          m_a   = req_a[32*m_sel +: 32];
          bb    = req_b[32*m_sel +: 32];
          m_b   = req_sub[m_sel] ? {~bb[31], bb[30:0]} : bb;
          m_data = fadd(m_a, m_b);
          m_err = 1'b0;
          ph    = 1;
        end
      end
      1: begin
        chk("issue_outs", {busy, fpu_start, grant, resp_valid},
            {1'b1, 1'b1, oh, 4'b0});
        chk("issue_a", fpu_a, m_a);
        chk("issue_b", fpu_b, m_b);
        m_cnt = 0;
        ph    = 2;
      end
      2: begin
        chk("wait_outs", {busy, fpu_start, grant, resp_valid},
            {1'b1, 1'b0, oh, 4'b0});
        if (fpu_done) ph = 3;
`ifdef FP_ARB_TIMEOUT_EN
        else if (m_cnt == TMO - 1) begin
          m_data = 32'h7FC0_0000;
          m_err  = 1'b1;
          ph     = 3;
        end else m_cnt++;
`endif
      end
      3: begin
        chk("resp_outs",
            {busy, fpu_start, grant, resp_valid, resp_err},
            {1'b1, 1'b0, oh, oh, m_err});
        chk("resp_data", resp_data, m_data);
        m_cnt = 0;
        ph    = m_err ? 4 : 0;
      end
      default: begin
        chk("flush_outs", {busy, fpu_start, grant, resp_valid},
            {1'b1, 1'b0, 4'b0, 4'b0});
        if (fpu_done || m_cnt == TMO - 1) ph = 0;
        else m_cnt++;
      end
    endcase
  endtask

  always @(negedge clk) begin
    #1;
    if (rst) begin
      ph    = 0;
      m_ptr = N - 1;
    end else begin
      model_step();
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_ctl"},
        {grant, resp_valid, resp_err, busy, fpu_start}, 0);
    chk({nm, "_data"}, {resp_data, fpu_a}, 0);
    chk({nm, "_fpub"}, fpu_b, 0);
  endtask

  task automatic run_single(input int idx, input logic sub,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eb,
                            input logic [31:0] ed,
                            input logic spur);
    logic [N-1:0] ev;
    ev = '0;
    ev[idx] = 1'b1;
    @(negedge clk);
    req[idx] = 1'b1;
    req_sub[idx] = sub;
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    @(negedge clk);
    if (spur) begin
      man_done = 1'b1;
      man_res  = 32'hDEAD_BEEF;
    end
    #1;
    chk("single_start", fpu_start, 1);
    chk("single_fpu_b", fpu_b, eb);
    chk("single_grant", grant, ev);
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      man_done = 1'b0;
      #1;
      if (k < 7) chk("single_early_rv", resp_valid, 0);
      else begin
        chk("single_rv", resp_valid, ev);
        chk("single_data", resp_data, ed);
      end
    end
    @(negedge clk);
    req[idx] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [N-1:0] gseq [8];
  int           ng;

  task automatic rr_run(input logic [N-1:0] mask);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        req[i] = 1'b1;
        req_sub[i] = 1'b0;
        req_a[32*i +: 32] = d2s(real'(i + 1));
        req_b[32*i +: 32] = d2s(2.0);
      end
    end
    ng = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (fpu_start && ng < 8) begin
        gseq[ng] = grant;
        ng++;
      end
      for (int i = 0; i < N; i++)
        if (resp_valid[i]) req[i] = 1'b0;
      if (req == '0 && !busy) break;
    end
    chk("rr_drain", {req, busy}, 0);
  endtask

  logic [N-1:0] exp4 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int gap [N];
  int served = 0;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_single(0, 1'b0, 32'h4040_0000, 32'h3F80_0000,
               32'h3F80_0000, 32'h4080_0000, 1'b0);
    run_single(2, 1'b1, 32'h40A0_0000, 32'h4000_0000,
               32'hC000_0000, 32'h4040_0000, 1'b0);

    @(negedge clk);
    man_done = 1'b1;
    man_res  = 32'hDEAD_BEEF;
    @(negedge clk);
    man_done = 1'b0;
    #1;
    chk("spur_idle", {busy, resp_valid}, 0);
    run_single(0, 1'b0, 32'h4120_0000, 32'h40A0_0000,
               32'h40A0_0000, 32'h4170_0000, 1'b1);

    do_reset();
    lat_fix = 0;
    rr_run(4'b1111);
    chk("rr_count", ng, 4);
    for (int i = 0; i < 4; i++) chk("rr_seq", gseq[i], exp4[i]);
    rr_run(4'b1001);
    chk("rr2_count", ng, 2);
    chk("rr2_first", gseq[0], 4'b0001);
    chk("rr2_second", gseq[1], 4'b1000);

    auto_en = 0;
    lat_fix = 5;
    @(negedge clk);
    req[3] = 1'b1;
    req_sub[3] = 1'b0;
    req_a[96 +: 32] = 32'h3F80_0000;
    req_b[96 +: 32] = 32'h3F80_0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_busy", {busy, grant}, {1'b1, 4'b1000});
    #2;
    rst = 1'b1;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req[3] = 1'b0;
    @(negedge clk);
    man_done = 1'b1;
    man_res  = 32'h1234_5678;
    @(negedge clk);
    man_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("mid_after", {busy, resp_valid}, 0);
    end
    auto_en = 1;
    run_single(1, 1'b0, 32'h4000_0000, 32'h4000_0000,
               32'h4000_0000, 32'h4080_0000, 1'b0);

    lat_fix = 0;
    for (int i = 0; i < N; i++) gap[i] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (resp_valid[i]) begin
            req[i] = 1'b0;
            gap[i] = $urandom_range(0, 3);
            served++;
          end
        end else if (cyc < 1800) begin
          if (gap[i] > 0) gap[i]--;
          else if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            req_sub[i] = ($urandom_range(0, 1) == 1);
            req_a[32*i +: 32] = rnd_f();
            req_b[32*i +: 32] = rnd_f();
          end
        end
      end
    end
    #1;
    chk("rand_drain", {req, busy}, 0);
    chk("rand_served", served > 100, 1);

`ifdef FP_ARB_TIMEOUT_EN
    auto_en = 0;
    lat_fix = 5;
    @(negedge clk);
    req[0] = 1'b1;
    req_sub[0] = 1'b0;
    req_a[0 +: 32] = 32'h4040_0000;
    req_b[0 +: 32] = 32'h3F80_0000;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      #1;
      if (k < 10) chk("tmo_early_rv", resp_valid, 0);
      else begin
        chk("tmo_rv", {resp_valid, resp_err}, {4'b0001, 1'b1});
        chk("tmo_data", resp_data, 32'h7FC0_0000);
      end
    end
    @(negedge clk);
    req[0] = 1'b0;
    #1;
    chk("tmo_flush", {busy, grant}, {1'b1, 4'b0});
    @(negedge clk);
    man_done = 1'b1;
    man_res  = 32'h1234_5678;
    @(negedge clk);
    man_done = 1'b0;
    #1;
    chk("tmo_after", {busy, resp_valid}, 0);
    auto_en = 1;
    run_single(1, 1'b1, 32'h4100_0000, 32'h3F80_0000,
               32'hBF80_0000, 32'h40E0_0000, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
